// File: rtl/cplx_reg_bank_p_pkg.sv
// Shared definitions for the complex register bank: write modes, constant table, clear FSM states.
// No logic of its own; cnst_word() is evaluated combinationally by the read ports.
// No flow control.
package cplx_rb_pkg;

    localparam logic [1:0] WM_FULL = 2'b00;
    localparam logic [1:0] WM_RE   = 2'b01;
    localparam logic [1:0] WM_IM   = 2'b10;
    localparam logic [1:0] WM_SWAP = 2'b11;

    localparam int NCONST           = 9;
    localparam int CI_ZERO          = 0;
    localparam int CI_ONE           = 1;
    localparam int CI_J             = 2;
    localparam int CI_ONE_J         = 3;
    localparam int CI_NEG_ONE       = 4;
    localparam int CI_NEG_J         = 5;
    localparam int CI_NEG_ONE_NEG_J = 6;
    localparam int CI_NEG_ONE_J     = 7;
    localparam int CI_ONE_NEG_J     = 8;

    // Widest half the constant builder can produce.
    localparam int CNST_MAX_HALF_W = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Builds {re, im} with each half sign-extended to half_w bits; word sits in the low 2*half_w bits.
    function automatic logic [2*CNST_MAX_HALF_W-1:0] cnst_word(input int idx, input int half_w);
        logic [1:0]                     re;
        logic [1:0]                     im;
        logic [2*CNST_MAX_HALF_W-1:0]   w;
        re = 2'b00;
        im = 2'b00;
        case (idx)
            CI_ONE:           re = 2'b01;
            CI_J:             im = 2'b01;
            CI_ONE_J:         begin re = 2'b01; im = 2'b01; end
            CI_NEG_ONE:       re = 2'b11;
            CI_NEG_J:         im = 2'b11;
            CI_NEG_ONE_NEG_J: begin re = 2'b11; im = 2'b11; end
            CI_NEG_ONE_J:     begin re = 2'b11; im = 2'b01; end
            CI_ONE_NEG_J:     begin re = 2'b01; im = 2'b11; end
            default:          ;
        endcase
        w = '0;
        for (int b = 0; b < CNST_MAX_HALF_W; b++) begin
            if (b < half_w) begin
                w[b]          = (b == 0) ? im[0] : im[1];
                w[b + half_w] = (b == 0) ? re[0] : re[1];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cplx_reg_bank_p_rdport.sv
// One read port: array mux, same-cycle write/clear forwarding, constant table, optional im negation.
// Latency 1: out_dat loads on the edge where en=1, out_vld is high for the following cycle.
// No backpressure; en alone decides whether the output register updates.
module cplx_rb_rdport
    import cplx_rb_pkg::*;
#(
    parameter int HALF_W = 32,
    parameter int NREGS  = 16,
    localparam int W     = 2 * HALF_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  regs [NREGS],
    input  logic [AW-1:0] sel,
    input  logic          cnst,
    input  logic          en,
    input  logic          conj,
    input  logic          fwd_vld,
    input  logic [AW-1:0] fwd_idx,
    input  logic [W-1:0]  fwd_dat,
    output logic [W-1:0]  out_dat,
    output logic          out_vld
);

    logic [2*CNST_MAX_HALF_W-1:0] cnst_full;
    logic [W-1:0]                 rd_dat;
    logic                         unused_cnst_bits;

    assign unused_cnst_bits = ^cnst_full;

    always_comb begin
        cnst_full = cnst_word(int'(sel), HALF_W);
        if (cnst) begin
            rd_dat = cnst_full[W-1:0];
        end else if (fwd_vld && (fwd_idx == sel)) begin
            rd_dat = fwd_dat;
        end else begin
            rd_dat = regs[sel];
        end
        // Negation wraps, so the most negative im maps to itself.
        if (conj) begin
            rd_dat[HALF_W-1:0] = -rd_dat[HALF_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_dat <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= en;
            if (en) begin
                out_dat <= rd_dat;
            end
        end
    end

endmodule

// File: rtl/cplx_reg_bank_p.sv
// Parametrised {re, im} register bank with partial writes, two forwarded read ports and a clear sweep.
// Read latency 1; the sweep runs NREGS cycles with busy high and drops writes meanwhile.
// No backpressure. Optional CPLX_RB_CONJ_EN adds conjA/conjB to negate the im half of reads.
module cplx_reg_bank_p
    import cplx_rb_pkg::*;
#(
    parameter int HALF_W = 32,
    parameter int NREGS  = 16,
    localparam int W     = 2 * HALF_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          regwen,
    input  logic [W-1:0]  inA,
    input  logic [AW-1:0] selwreg,
    input  logic [1:0]    endwreg,
    input  logic [AW-1:0] seloutA,
    input  logic [AW-1:0] seloutB,
    input  logic          cnstA,
    input  logic          cnstB,
    input  logic          enrregA,
    input  logic          enrregB,
`ifdef CPLX_RB_CONJ_EN
    input  logic          conjA,
    input  logic          conjB,
`endif
    output logic [W-1:0]  outA,
    output logic [W-1:0]  outB,
    output logic          validA,
    output logic          validB,
    input  logic          clr_req,
    output logic          busy
);

    logic [W-1:0]  regs [NREGS];
    clr_state_t    state;
    logic [AW-1:0] clr_cnt;
    logic          wr_go;
    logic [W-1:0]  cur_word;
    logic [W-1:0]  merged;
    logic          fwd_vld;
    logic [AW-1:0] fwd_idx;
    logic [W-1:0]  fwd_dat;
    logic          conj_a;
    logic          conj_b;

`ifdef CPLX_RB_CONJ_EN
    assign conj_a = conjA;
    assign conj_b = conjB;
`else
    assign conj_a = 1'b0;
    assign conj_b = 1'b0;
`endif

    assign busy     = (state == CLEAR);
    assign wr_go    = regwen && (state == IDLE);
    assign cur_word = regs[selwreg];

    always_comb begin
        merged = inA;
        case (endwreg)
            WM_FULL: merged = inA;
            WM_RE:   merged = {inA[W-1:HALF_W], cur_word[HALF_W-1:0]};
            WM_IM:   merged = {cur_word[W-1:HALF_W], inA[HALF_W-1:0]};
            WM_SWAP: merged = {inA[HALF_W-1:0], inA[W-1:HALF_W]};
            default: merged = inA;
        endcase
    end

    // Single array write port, shared by the sweep and normal writes; both read ports see it forwarded.
    always_comb begin
        fwd_vld = 1'b0;
        fwd_idx = '0;
        fwd_dat = '0;
        if (state == CLEAR) begin
            fwd_vld = 1'b1;
            fwd_idx = clr_cnt;
        end else if (wr_go) begin
            fwd_vld = 1'b1;
            fwd_idx = selwreg;
            fwd_dat = merged;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            if (fwd_vld) begin
                regs[fwd_idx] <= fwd_dat;
            end
            case (state)
                IDLE: begin
                    clr_cnt <= '0;
                    if (clr_req) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cplx_rb_rdport #(.HALF_W(HALF_W), .NREGS(NREGS)) u_rd_a (
        .clock   (clock),
        .reset   (reset),
        .regs    (regs),
        .sel     (seloutA),
        .cnst    (cnstA),
        .en      (enrregA),
        .conj    (conj_a),
        .fwd_vld (fwd_vld),
        .fwd_idx (fwd_idx),
        .fwd_dat (fwd_dat),
        .out_dat (outA),
        .out_vld (validA)
    );

    cplx_rb_rdport #(.HALF_W(HALF_W), .NREGS(NREGS)) u_rd_b (
        .clock   (clock),
        .reset   (reset),
        .regs    (regs),
        .sel     (seloutB),
        .cnst    (cnstB),
        .en      (enrregB),
        .conj    (conj_b),
        .fwd_vld (fwd_vld),
        .fwd_idx (fwd_idx),
        .fwd_dat (fwd_dat),
        .out_dat (outB),
        .out_vld (validB)
    );

endmodule

// File: tb/tb_cplx_reg_bank_p.sv
// Scoreboard bench for cplx_reg_bank_p: directed reads push hand-computed words, a negedge monitor pops and compares.
module tb_cplx_reg_bank_p;

    localparam int HALF_W = 32;
    localparam int NREGS  = 16;
    localparam int W      = 64;
    localparam int AW     = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          regwen;
    logic [W-1:0]  inA;
    logic [AW-1:0] selwreg;
    logic [1:0]    endwreg;
    logic [AW-1:0] seloutA, seloutB;
    logic          cnstA, cnstB;
    logic          enrregA, enrregB;
`ifdef CPLX_RB_CONJ_EN
    logic          conjA, conjB;
`endif
    logic [W-1:0]  outA, outB;
    logic          validA, validB;
    logic          clr_req;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  qA [$];
    logic [W-1:0]  qB [$];
    logic [W-1:0]  lastA, lastB;
    int            busy_cnt;

    always #5 clock = ~clock;

    cplx_reg_bank_p #(.HALF_W(HALF_W), .NREGS(NREGS)) dut (
        .clock   (clock),
        .reset   (reset),
        .regwen  (regwen),
        .inA     (inA),
        .selwreg (selwreg),
        .endwreg (endwreg),
        .seloutA (seloutA),
        .seloutB (seloutB),
        .cnstA   (cnstA),
        .cnstB   (cnstB),
        .enrregA (enrregA),
        .enrregB (enrregB),
`ifdef CPLX_RB_CONJ_EN
        .conjA   (conjA),
        .conjB   (conjB),
`endif
        .outA    (outA),
        .outB    (outB),
        .validA  (validA),
        .validB  (validB),
        .clr_req (clr_req),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clock) begin
        if (validA) begin
            if (qA.size() == 0) check("rdA_unexpected_valid", 64'd1, 64'd0);
            else                check("rdA_data", outA, qA.pop_front());
        end
        if (validB) begin
            if (qB.size() == 0) check("rdB_unexpected_valid", 64'd1, 64'd0);
            else                check("rdB_data", outB, qB.pop_front());
        end
    end

    task automatic idle();
        regwen  = 1'b0;
        clr_req = 1'b0;
        enrregA = 1'b0;
        enrregB = 1'b0;
        cnstA   = 1'b0;
        cnstB   = 1'b0;
`ifdef CPLX_RB_CONJ_EN
        conjA   = 1'b0;
        conjB   = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic wr(input int idx, input logic [1:0] mode, input logic [W-1:0] dat);
        regwen  = 1'b1;
        selwreg = AW'(idx);
        endwreg = mode;
        inA     = dat;
    endtask

    task automatic rd_a(input int idx, input logic cn, input logic [W-1:0] exp);
        seloutA = AW'(idx);
        cnstA   = cn;
        enrregA = 1'b1;
        qA.push_back(exp);
        lastA   = exp;
    endtask

    task automatic rd_b(input int idx, input logic cn, input logic [W-1:0] exp);
        seloutB = AW'(idx);
        cnstB   = cn;
        enrregB = 1'b1;
        qB.push_back(exp);
        lastB   = exp;
    endtask

    task automatic check_hold();
        idle();
        step();
        @(negedge clock);
        check("validA_low", {63'd0, validA}, 64'd0);
        check("outA_hold", outA, lastA);
        check("validB_low", {63'd0, validB}, 64'd0);
        check("outB_hold", outB, lastB);
    endtask

    function automatic logic [W-1:0] fill(input int i);
        return {32'h100 + 32'(i), 32'h200 + 32'(i)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        lastA = '0;
        lastB = '0;
        seloutA = '0;
        seloutB = '0;
        // Reset must win over a simultaneous write and read load.
        reset = 1'b0;
        wr(3, cplx_rb_pkg::WM_FULL, 64'hDEADBEEF_00001111);
        enrregA = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_outA", outA, 64'd0);
        check("rst_outB", outB, 64'd0);
        check("rst_validA", {63'd0, validA}, 64'd0);
        check("rst_validB", {63'd0, validB}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;
        idle();
        rd_a(3, 1'b0, 64'd0);
        rd_b(9, 1'b0, 64'd0);
        step();
        check_hold();

        // Full and partial writes
        wr(3, cplx_rb_pkg::WM_FULL, 64'h00000005_FFFFFFFE); step();
        rd_a(3, 1'b0, 64'h00000005_FFFFFFFE); step();
        wr(3, cplx_rb_pkg::WM_RE, 64'h11111111_22222222); step();
        rd_a(3, 1'b0, 64'h11111111_FFFFFFFE); step();
        wr(3, cplx_rb_pkg::WM_IM, 64'h33333333_44444444); step();
        rd_a(3, 1'b0, 64'h11111111_44444444); step();
        wr(3, cplx_rb_pkg::WM_SWAP, 64'hAAAAAAAA_BBBBBBBB); step();
        rd_a(3, 1'b0, 64'hBBBBBBBB_AAAAAAAA); step();
        // Forwarded partial write, then the committed value
        wr(3, cplx_rb_pkg::WM_RE, 64'hCCCCCCCC_DDDDDDDD);
        rd_a(3, 1'b0, 64'hCCCCCCCC_AAAAAAAA); step();
        rd_b(3, 1'b0, 64'hCCCCCCCC_AAAAAAAA); step();
        wr(7, cplx_rb_pkg::WM_FULL, 64'h00000001_00000002);
        rd_b(7, 1'b0, 64'h00000001_00000002); step();
        check_hold();

        // Constant table
        rd_a(6, 1'b1, 64'hFFFFFFFF_FFFFFFFF); rd_b(4, 1'b1, 64'hFFFFFFFF_00000000); step();
        rd_a(8, 1'b1, 64'h00000001_FFFFFFFF); rd_b(2, 1'b1, 64'h00000000_00000001); step();
        rd_a(12, 1'b1, 64'd0);                rd_b(15, 1'b1, 64'd0);                step();
        rd_a(5, 1'b1, 64'h00000000_FFFFFFFF); rd_b(7, 1'b1, 64'hFFFFFFFF_00000001); step();
        wr(3, cplx_rb_pkg::WM_FULL, 64'h00000009_00000009);
        rd_a(3, 1'b1, 64'h00000001_00000001); rd_b(0, 1'b1, 64'd0); step();
        check_hold();

        // Clear sweep
        for (int i = 0; i < NREGS; i++) begin
            wr(i, cplx_rb_pkg::WM_FULL, fill(i)); step();
        end
        clr_req = 1'b1; step();
        busy_cnt = 0;
        for (int i = 0; i < NREGS; i++) begin
            if (i == 3)  clr_req = 1'b1;
            if (i == 8)  wr(2, cplx_rb_pkg::WM_FULL, 64'hDEADBEEF_CAFEF00D);
            if (i == 10) begin
                rd_a(15, 1'b0, fill(15));
                rd_b(10, 1'b0, 64'd0);
            end
            @(negedge clock);
            if (busy) busy_cnt++;
            step();
        end
        @(negedge clock);
        check("busy_after_sweep", {63'd0, busy}, 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'd16);
        for (int i = 0; i < NREGS; i++) begin
            rd_a(i, 1'b0, 64'd0); rd_b(NREGS - 1 - i, 1'b0, 64'd0); step();
        end
        check_hold();

        // Reset during the sweep
        for (int i = 0; i < NREGS; i++) begin
            wr(i, cplx_rb_pkg::WM_FULL, fill(i)); step();
        end
        clr_req = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rd_a(14, 1'b0, fill(14));
                rd_b(13, 1'b0, fill(13));
            end
            step();
        end
        reset = 1'b0; step();
        @(negedge clock);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_outA", outA, 64'd0);
        check("midrst_outB", outB, 64'd0);
        check("midrst_validA", {63'd0, validA}, 64'd0);
        lastA = '0;
        lastB = '0;
        reset = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            rd_a(i, 1'b0, 64'd0); rd_b(NREGS - 1 - i, 1'b0, 64'd0); step();
        end
        check_hold();

`ifdef CPLX_RB_CONJ_EN
        wr(4, cplx_rb_pkg::WM_FULL, 64'h00000003_00000005); step();
        conjA = 1'b1; rd_a(4, 1'b0, 64'h00000003_FFFFFFFB);
        conjB = 1'b1; rd_b(6, 1'b1, 64'hFFFFFFFF_00000001); step();
        wr(5, cplx_rb_pkg::WM_FULL, 64'h00000000_80000000); step();
        conjA = 1'b1; rd_a(5, 1'b0, 64'h00000000_80000000); step();
        check_hold();
`endif

        for (int k = 0; k < 10; k++) begin
            if (qA.size() == 0 && qB.size() == 0) break;
            step();
        end
        check("qA_drained", 64'(qA.size()), 64'd0);
        check("qB_drained", 64'(qB.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
